// File: rtl/mem_access_scheduler.sv
// -----------------------------------------------------------------------------
// mem_access_scheduler
//
// Round-robin scheduler that shares one single-port memory between three
// requesters. An owner keeps the memory for up to MAX_BURST back-to-back
// transactions while it keeps requesting; ownership then rotates, and one
// idle cycle always separates two owners. Each transaction is a one-cycle
// mem_start pulse followed by a wait for mem_done. If mem_done does not arrive
// within TIMEOUT_CYCLES wait cycles, the transaction is completed anyway and
// flagged with err.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   req        per-requester level request (bit i = requester i)
//   req_addr   per-requester address, slice i = requester i
//   req_wdata  per-requester write data, slice i = requester i
//   req_we     per-requester write enable (1 = write, 0 = read)
//   grant      one-hot current owner, 0 when idle
//   ack        one-cycle completion pulse for the owner
//   err        one-cycle pulse with ack when the completion was a timeout
//   rdata      read data of the last successful read
//   mem_start  one-cycle transaction start
//   mem_addr   address, held from one start until the next
//   mem_wdata  write data, held likewise
//   mem_we     write enable, held likewise
//   mem_done   completion from memory, only looked at while waiting
//   mem_rdata  read data, valid with mem_done
// -----------------------------------------------------------------------------
module mem_access_scheduler #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int MAX_BURST      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [3*DATA_W-1:0]   req_wdata,
   input  logic [2:0]            req_we,
   output logic [2:0]            grant,
   output logic [2:0]            ack,
   output logic [2:0]            err,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_start,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_we,
   input  logic                  mem_done,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int TO_W    = $clog2(TIMEOUT_CYCLES);

   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t             state;
   logic [1:0]         owner;
   logic [1:0]         last_owner;
   logic [BURST_W-1:0] burst_cnt;
   logic [TO_W-1:0]    to_cnt;

   // Arbitration result and the slice selected for the next issue.
   logic               pick_valid;
   logic [1:0]         pick_idx;
   logic [1:0]         start_idx;
   logic [2:0]         cand_sum;
   logic [1:0]         cand;
   logic [1:0]         load_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

   logic               complete;
   logic               keep_owner;

   // Round-robin scan: start just after the previous owner and wrap mod 3.
   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      cand_sum   = 3'd0;
      cand       = 2'd0;
      start_idx  = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
      for (int k = 0; k < 3; k++) begin
         cand_sum = {1'b0, start_idx} + 3'(k);
         cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // A fresh grant loads the picked requester; a burst continuation reloads
   // the current owner's slices.
   assign load_idx = (state == S_IDLE) ? pick_idx : owner;

   always_comb begin
      sel_addr  = req_addr[0 +: ADDR_W];
      sel_wdata = req_wdata[0 +: DATA_W];
      sel_we    = req_we[0];
      case (load_idx)
         2'd1: begin
            sel_addr  = req_addr[ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[DATA_W +: DATA_W];
            sel_we    = req_we[1];
         end
         2'd2: begin
            sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[2*DATA_W +: DATA_W];
            sel_we    = req_we[2];
         end
         default: ;
      endcase
   end

   // mem_done on the timeout edge is a normal completion, so it wins over err.
   assign complete   = mem_done || (to_cnt == TO_LAST);
   assign keep_owner = req[owner] && (burst_cnt < BURST_MAX);

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the values from before the edge, independent of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= 2'd0;
         last_owner <= 2'd2;
         burst_cnt  <= '0;
         to_cnt     <= '0;
         grant      <= '0;
         ack        <= '0;
         err        <= '0;
         rdata      <= '0;
         mem_start  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
      end else begin
         // Pulses default low and are raised only on the edge that needs them.
         ack       <= '0;
         err       <= '0;
         mem_start <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  state     <= S_ISSUE;
                  owner     <= pick_idx;
                  grant     <= 3'b001 << pick_idx;
                  burst_cnt <= BURST_W'(1);
                  mem_start <= 1'b1;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_we    <= sel_we;
               end else begin
                  grant <= '0;
               end
            end

            S_ISSUE: begin
               state  <= S_WAIT;
               to_cnt <= '0;
            end

            S_WAIT: begin
               if (complete) begin
                  ack[owner] <= 1'b1;
                  err[owner] <= ~mem_done;
                  if (mem_done && !mem_we) begin
                     rdata <= mem_rdata;
                  end
                  if (keep_owner) begin
                     state     <= S_ISSUE;
                     burst_cnt <= burst_cnt + BURST_W'(1);
                     mem_start <= 1'b1;
                     mem_addr  <= sel_addr;
                     mem_wdata <= sel_wdata;
                     mem_we    <= sel_we;
                  end else begin
                     state      <= S_IDLE;
                     grant      <= '0;
                     last_owner <= owner;
                  end
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
